// File: rtl/mux16_ser_pkg.sv
// Shared types, widths and select-index helpers for the 16-bit parallel-to-serial stage.
package mux16_ser_pkg;

  localparam int SEL_W  = 4;
  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // First bit position sent for a word.
  function automatic logic [SEL_W-1:0] start_idx(input logic msb_first);
    return msb_first ? 4'd15 : 4'd0;
  endfunction

  // Final bit position of a word; the beat at this index ends the transfer.
  function automatic logic [SEL_W-1:0] end_idx(input logic msb_first);
    return msb_first ? 4'd0 : 4'd15;
  endfunction

endpackage

// File: rtl/mux16to1.sv
// Plain 16:1 bit multiplexer: out follows in[sel] with no storage.
module mux16to1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/mux16_serializer.sv
// Holds one 16-bit word and streams it out one bit per valid/ready beat,
// walking a 4-bit select through the 16:1 mux in LSB- or MSB-first order.
module mux16_serializer
  import mux16_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  if (WIDTH != WORD_W) begin : g_bad_width
    $error("mux16_serializer: WIDTH must be 16 to match the 4-bit select");
  end

  localparam logic [SEL_W-1:0] START_SEL = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_SEL   = end_idx(MSB_FIRST);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] word_r;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_next_s;
  logic             load_s;
  logic             beat_s;
  logic             final_beat_s;

  // Next-state, load and select-counter decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    beat_s       = 1'b0;
    final_beat_s = 1'b0;
    sel_next_s   = sel_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s       = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          beat_s = 1'b1;
          if (sel_r == END_SEL) begin
            final_beat_s = 1'b1;
            next_state_s = IDLE;
          end else begin
            next_state_s = SHIFT;
          end
        end else begin
          next_state_s = SHIFT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // The counter only ever wraps by returning to the start index.
    if (load_s || final_beat_s) begin
      sel_next_s = START_SEL;
    end else if (beat_s) begin
      if (MSB_FIRST) begin
        sel_next_s = sel_r - 4'd1;
      end else begin
        sel_next_s = sel_r + 4'd1;
      end
    end else begin
      sel_next_s = sel_r;
    end
  end

  // State, held word and select register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      word_r  <= {WIDTH{1'b0}};
      sel_r   <= START_SEL;
    end else begin
      state_r <= next_state_s;
      sel_r   <= sel_next_s;
      if (load_s) begin
        word_r <= in_data;
      end
    end
  end

  mux16to1 u_mux (
    .in  (word_r),
    .sel (sel_r),
    .out (ser_out)
  );

  assign in_ready  = (state_r == IDLE);
  assign ser_valid = (state_r == SHIFT);
  assign busy      = (state_r == SHIFT);
  assign ser_last  = ser_valid && (sel_r == END_SEL);
  assign sel       = sel_r;

endmodule

// File: tb/tb_mux16_serializer.sv
// Drives an LSB-first and an MSB-first serializer in lockstep; checks a vector table,
// hand-written reset/backpressure sequences and random traffic against a beat-index model.
module tb_mux16_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        ser_ready;
  logic [15:0] in_data;

  logic        in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
  logic [3:0]  sel_l;
  logic        in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic [3:0]  sel_m;

  int errors = 0;
  int checks = 0;

  // Model: a word in flight is just a stored word plus how many beats have gone out.
  bit          m_busy;
  int          m_k;
  logic [15:0] m_word;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_l;
    logic [15:0] exp_m;
    int          stall_at;
    int          stall_len;
    bit          hold_busy;
  } vec_t;

  vec_t vecs[6];

  mux16_serializer #(.MSB_FIRST(1'b0), .WIDTH(16)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_last(ser_last_l),
    .ser_ready(ser_ready), .sel(sel_l), .busy(busy_l)
  );

  mux16_serializer #(.MSB_FIRST(1'b1), .WIDTH(16)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_last(ser_last_m),
    .ser_ready(ser_ready), .sel(sel_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input bit msb);
    if (!m_busy) return msb ? 4'd15 : 4'd0;
    return msb ? 4'(15 - m_k) : 4'(m_k);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_k    = 0;
    m_word = 16'h0000;
  endtask

  task automatic model_compare();
    check("lsb in_ready",  16'(in_ready_l),  16'(!m_busy));
    check("lsb ser_valid", 16'(ser_valid_l), 16'(m_busy));
    check("lsb busy",      16'(busy_l),      16'(m_busy));
    check("lsb sel",       16'(sel_l),       16'(exp_sel(1'b0)));
    check("lsb ser_out",   16'(ser_out_l),   16'(m_word[exp_sel(1'b0)]));
    check("lsb ser_last",  16'(ser_last_l),  16'(m_busy && m_k == 15));
    check("msb in_ready",  16'(in_ready_m),  16'(!m_busy));
    check("msb ser_valid", 16'(ser_valid_m), 16'(m_busy));
    check("msb busy",      16'(busy_m),      16'(m_busy));
    check("msb sel",       16'(sel_m),       16'(exp_sel(1'b1)));
    check("msb ser_out",   16'(ser_out_m),   16'(m_word[exp_sel(1'b1)]));
    check("msb ser_last",  16'(ser_last_m),  16'(m_busy && m_k == 15));
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (in_valid) begin
        m_word = in_data;
        m_k    = 0;
        m_busy = 1'b1;
      end
    end else if (ser_ready) begin
      if (m_k == 15) begin
        m_busy = 1'b0;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
    @(negedge clk);
    model_compare();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  16'(in_ready_l),  16'd1);
    check({tag, " ser_valid"}, 16'(ser_valid_l), 16'd0);
    check({tag, " busy"},      16'(busy_l),      16'd0);
    check({tag, " sel lsb"},   16'(sel_l),       16'd0);
    check({tag, " sel msb"},   16'(sel_m),       16'd15);
    check({tag, " ser_last"},  16'(ser_last_l | ser_last_m), 16'd0);
  endtask

  task automatic run_word(input vec_t v);
    check("pre in_ready", 16'(in_ready_l & in_ready_m), 16'd1);
    in_valid  = 1'b1;
    in_data   = v.word;
    ser_ready = 1'b1;
    step();
    in_valid = v.hold_busy;
    in_data  = v.hold_busy ? 16'h0000 : ~v.word;
    for (int k = 0; k < 16; k++) begin
      check("vec sel lsb",      16'(sel_l),       16'(k));
      check("vec sel msb",      16'(sel_m),       16'(15 - k));
      check("vec ser_out lsb",  16'(ser_out_l),   16'(v.exp_l[k]));
      check("vec ser_out msb",  16'(ser_out_m),   16'(v.exp_m[k]));
      check("vec ser_last lsb", 16'(ser_last_l),  16'(k == 15));
      check("vec ser_last msb", 16'(ser_last_m),  16'(k == 15));
      check("vec ser_valid",    16'(ser_valid_l & ser_valid_m), 16'd1);
      check("vec in_ready",     16'(in_ready_l | in_ready_m),   16'd0);
      if (k == v.stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          step();
          check("stall sel lsb",      16'(sel_l),      16'(k));
          check("stall ser_out lsb",  16'(ser_out_l),  16'(v.exp_l[k]));
          check("stall ser_out msb",  16'(ser_out_m),  16'(v.exp_m[k]));
          check("stall ser_last lsb", 16'(ser_last_l), 16'(k == 15));
        end
        ser_ready = 1'b1;
      end
      step();
    end
    check("drain in_ready", 16'(in_ready_l & in_ready_m), 16'd1);
    check("drain busy",     16'(busy_l | busy_m),         16'd0);
    check("drain ser_valid", 16'(ser_valid_l | ser_valid_m), 16'd0);
    if (!v.hold_busy) in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_idle(tag);
    check({tag, " ser_out"}, 16'(ser_out_l | ser_out_m), 16'd0);
    step();
    rst = 1'b0;
    step();
    check_idle(tag);
  endtask

  initial begin
    vecs[0] = '{word: 16'hF0A5, exp_l: 16'hF0A5, exp_m: 16'hA50F, stall_at: -1, stall_len: 0, hold_busy: 1'b0};
    vecs[1] = '{word: 16'h8001, exp_l: 16'h8001, exp_m: 16'h8001, stall_at: 5,  stall_len: 3, hold_busy: 1'b0};
    vecs[2] = '{word: 16'hFFFF, exp_l: 16'hFFFF, exp_m: 16'hFFFF, stall_at: -1, stall_len: 0, hold_busy: 1'b1};
    vecs[3] = '{word: 16'h0000, exp_l: 16'h0000, exp_m: 16'h0000, stall_at: -1, stall_len: 0, hold_busy: 1'b0};
    vecs[4] = '{word: 16'h1234, exp_l: 16'h1234, exp_m: 16'h2C48, stall_at: 2,  stall_len: 1, hold_busy: 1'b0};
    vecs[5] = '{word: 16'h5A3C, exp_l: 16'h5A3C, exp_m: 16'h3C5A, stall_at: 15, stall_len: 2, hold_busy: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    ser_ready = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("reset");

    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i]);
    end

    // Reset in the middle of 16'hAAAA, then a fresh word.
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("midword sel", 16'(sel_l), 16'd7);
    do_reset("midreset");
    run_word('{word: 16'h0001, exp_l: 16'h0001, exp_m: 16'h8000, stall_at: -1, stall_len: 0, hold_busy: 1'b0});

    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    in_valid  = 1'b0;
    ser_ready = 1'b0;
    do_reset("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
